// File: rtl/sb_trans_decoder.sv
// Sideband receive transaction decoder: parses DLE/STX/ETX AT frames and DLE/LSE/CLSE LT frames,
// checks AT CRC-16, and commits captured fields with a one-cycle strobe one edge after the last byte.
module sb_trans_decoder #(
    parameter int DATA_BYTES = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic                    sb_clk,
    input  logic                    rst,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_valid,
    input  logic                    rx_en,
    output logic [2:0]              trans_type,
    output logic                    trans_valid,
    output logic [7:0]              rx_addr,
    output logic [7:0]              rx_len,
    output logic [8*DATA_BYTES-1:0] rx_data,
    output logic [7:0]              rx_lse,
    output logic                    crc_err,
    output logic                    frame_err
);

    typedef enum logic [3:0] {
        IDLE, DLE1, LT_CLSE, AT_ADDR, AT_LEN, AT_DATA, CRC_HI, CRC_LO, DLE2, ETX
    } state_t;

    localparam int             CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO_M1 = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  TMO_MX = CW'(TIMEOUT);
    localparam logic [1:0]     LAST_K = 2'(DATA_BYTES - 1);

    state_t                  state_q, state_d, cur;
    logic [CW-1:0]           idle_q, idle_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [15:0]             crc_q, crc_d, crc_rx_q, crc_rx_d;
    logic [2:0]              typ_sh_q, typ_sh_d;
    logic [7:0]              addr_sh_q, addr_sh_d, len_sh_q, len_sh_d, lse_sh_q, lse_sh_d;
    logic [8*DATA_BYTES-1:0] data_sh_q, data_sh_d;
    logic [2:0]              type_q, type_d;
    logic [7:0]              addr_q, addr_d, len_q, len_d, lse_q, lse_d;
    logic [8*DATA_BYTES-1:0] data_q, data_d;
    logic                    tv_q, tv_d, ce_q, ce_d, fe_q, fe_d;
    logic                    tmo;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        idle_d    = idle_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        crc_rx_d  = crc_rx_q;
        typ_sh_d  = typ_sh_q;
        addr_sh_d = addr_sh_q;
        len_sh_d  = len_sh_q;
        lse_sh_d  = lse_sh_q;
        data_sh_d = data_sh_q;
        type_d    = type_q;
        addr_d    = addr_q;
        len_d     = len_q;
        lse_d     = lse_q;
        data_d    = data_q;
        tv_d      = 1'b0;
        ce_d      = 1'b0;
        fe_d      = 1'b0;
        tmo       = 1'b0;
        cur       = state_q;

        if (!rx_en) begin
            state_d = IDLE;
            idle_d  = '0;
            cnt_d   = '0;
        end else begin
            tmo = (state_q != IDLE) && (idle_q >= TMO_M1);
            if (rx_valid)             idle_d = '0;
            else if (idle_q != TMO_MX) idle_d = idle_q + 1'b1;
            // A late byte still gets parsed, but from IDLE after the timeout error.
            if (tmo) begin
                fe_d    = 1'b1;
                cur     = IDLE;
                state_d = IDLE;
            end
            if (cur == IDLE) cnt_d = '0;

            if (rx_valid) begin
                case (cur)
                    IDLE: if (rx_byte == 8'hFE) begin
                        state_d = DLE1;
                        crc_d   = 16'hFFFF;
                    end
                    DLE1: case (rx_byte)
                        8'h05: begin typ_sh_d = 3'd2; crc_d = crc_step(crc_q, rx_byte); state_d = AT_ADDR; end
                        8'h04: begin typ_sh_d = 3'd3; crc_d = crc_step(crc_q, rx_byte); state_d = AT_ADDR; end
                        8'h80: begin lse_sh_d = rx_byte; state_d = LT_CLSE; end
                        8'hFE: crc_d = 16'hFFFF;
                        default: begin fe_d = 1'b1; state_d = IDLE; end
                    endcase
                    LT_CLSE: begin
                        state_d = IDLE;
                        if (rx_byte == ~lse_sh_q) begin
                            lse_d  = lse_sh_q;
                            type_d = 3'd4;
                            tv_d   = 1'b1;
                        end else begin
                            fe_d = 1'b1;
                        end
                    end
                    AT_ADDR: begin
                        addr_sh_d = rx_byte;
                        crc_d     = crc_step(crc_q, rx_byte);
                        state_d   = AT_LEN;
                    end
                    AT_LEN: begin
                        len_sh_d = rx_byte;
                        crc_d    = crc_step(crc_q, rx_byte);
                        if (typ_sh_q == 3'd3) begin
                            cnt_d   = '0;
                            state_d = AT_DATA;
                        end else begin
                            state_d = CRC_HI;
                        end
                    end
                    AT_DATA: begin
                        for (int k = 0; k < DATA_BYTES; k++)
                            if (cnt_q == 2'(k)) data_sh_d[8*k +: 8] = rx_byte;
                        crc_d = crc_step(crc_q, rx_byte);
                        if (cnt_q != 2'd3)   cnt_d   = cnt_q + 2'd1;
                        if (cnt_q == LAST_K) state_d = CRC_HI;
                    end
                    CRC_HI: begin crc_rx_d[15:8] = rx_byte; state_d = CRC_LO; end
                    CRC_LO: begin crc_rx_d[7:0]  = rx_byte; state_d = DLE2;   end
                    DLE2: begin
                        if (rx_byte == 8'hFE) state_d = ETX;
                        else begin fe_d = 1'b1; state_d = IDLE; end
                    end
                    ETX: begin
                        state_d = IDLE;
                        if (rx_byte != 8'h40)      fe_d = 1'b1;
                        else if (crc_rx_q != crc_q) ce_d = 1'b1;
                        else begin
                            type_d = typ_sh_q;
                            addr_d = addr_sh_q;
                            len_d  = len_sh_q;
                            if (typ_sh_q == 3'd3) data_d = data_sh_q;
                            tv_d   = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idle_q    <= '0;
            cnt_q     <= '0;
            crc_q     <= '0;
            crc_rx_q  <= '0;
            typ_sh_q  <= '0;
            addr_sh_q <= '0;
            len_sh_q  <= '0;
            lse_sh_q  <= '0;
            data_sh_q <= '0;
            type_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            lse_q     <= '0;
            data_q    <= '0;
            tv_q      <= 1'b0;
            ce_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idle_q    <= idle_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            crc_rx_q  <= crc_rx_d;
            typ_sh_q  <= typ_sh_d;
            addr_sh_q <= addr_sh_d;
            len_sh_q  <= len_sh_d;
            lse_sh_q  <= lse_sh_d;
            data_sh_q <= data_sh_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            lse_q     <= lse_d;
            data_q    <= data_d;
            tv_q      <= tv_d;
            ce_q      <= ce_d;
            fe_q      <= fe_d;
        end
    end

    assign trans_type  = type_q;
    assign trans_valid = tv_q;
    assign rx_addr     = addr_q;
    assign rx_len      = len_q;
    assign rx_data     = data_q;
    assign rx_lse      = lse_q;
    assign crc_err     = ce_q;
    assign frame_err   = fe_q;

endmodule

// File: tb/tb_sb_trans_decoder.sv
// Scoreboard bench for sb_trans_decoder: frames are built from intent (good/corrupted), expected
// pulses and field values are queued at issue time and checked by an independent monitor.
module tb_sb_trans_decoder;
    localparam int DB  = 3;
    localparam int TMO = 64;

    logic        sb_clk = 1'b0;
    logic        rst, rx_valid, rx_en;
    logic [7:0]  rx_byte;
    logic [2:0]  trans_type;
    logic        trans_valid, crc_err, frame_err;
    logic [7:0]  rx_addr, rx_len, rx_lse;
    logic [23:0] rx_data;

    sb_trans_decoder #(.DATA_BYTES(DB), .TIMEOUT(TMO)) dut (
        .sb_clk(sb_clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_en(rx_en),
        .trans_type(trans_type), .trans_valid(trans_valid), .rx_addr(rx_addr), .rx_len(rx_len),
        .rx_data(rx_data), .rx_lse(rx_lse), .crc_err(crc_err), .frame_err(frame_err)
    );

    always #5 sb_clk = ~sb_clk;

    typedef struct {
        logic [2:0]  pulse;   // {frame_err, crc_err, trans_valid}
        logic [2:0]  typ;
        logic [7:0]  addr, len, lse;
        logic [23:0] data;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  fr[$];
    logic [2:0]  m_typ;
    logic [7:0]  m_addr, m_len, m_lse;
    logic [23:0] m_data;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [15:0] crc16(input logic [7:0] m[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (m[i])
            for (int b = 7; b >= 0; b--)
                c = {c[14:0], 1'b0} ^ (((c[15] ^ m[i][b]) != 1'b0) ? 16'h8005 : 16'h0000);
        return c;
    endfunction

    task automatic push(input logic [2:0] p);
        exp_t e;
        e.pulse = p; e.typ = m_typ; e.addr = m_addr; e.len = m_len; e.lse = m_lse; e.data = m_data;
        expq.push_back(e);
    endtask

    task automatic expect_at(input logic [2:0] typ, input logic [7:0] a, l, input logic [23:0] d);
        m_typ = typ; m_addr = a; m_len = l;
        if (typ == 3'd3) m_data = d;
        push(3'b001);
    endtask

    task automatic expect_lt();
        m_typ = 3'd4; m_lse = 8'h80;
        push(3'b001);
    endtask

    task automatic mk_at(input logic [2:0] typ, input logic [7:0] a, l, input logic [23:0] d,
                         input logic [15:0] cx, input logic [7:0] dle2, etx);
        logic [7:0]  body[$];
        logic [15:0] c;
        body.push_back(typ == 3'd2 ? 8'h05 : 8'h04);
        body.push_back(a);
        body.push_back(l);
        if (typ == 3'd3) for (int k = 0; k < DB; k++) body.push_back(d[8*k +: 8]);
        c = crc16(body) ^ cx;
        fr.delete();
        fr.push_back(8'hFE);
        foreach (body[i]) fr.push_back(body[i]);
        fr.push_back(c[15:8]);
        fr.push_back(c[7:0]);
        fr.push_back(dle2);
        fr.push_back(etx);
    endtask

    task automatic tick();
        @(posedge sb_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            rx_byte = 8'($urandom);
            tick();
        end
    endtask

    function automatic int rgap();
        return ($urandom_range(0, 19) == 0) ? TMO - 2 : int'($urandom_range(0, 3));
    endfunction

    task automatic send_frame(input bit tight);
        foreach (fr[i]) send(fr[i], tight ? 0 : rgap());
    endtask

    task automatic drain();
        repeat (3) tick();
        chk("drain_pending", expq.size(), 0);
        expq.delete();
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, "_type"}, 32'(trans_type), 32'(m_typ));
        chk({tag, "_addr"}, 32'(rx_addr), 32'(m_addr));
        chk({tag, "_len"},  32'(rx_len),  32'(m_len));
        chk({tag, "_data"}, 32'(rx_data), 32'(m_data));
        chk({tag, "_lse"},  32'(rx_lse),  32'(m_lse));
        chk({tag, "_pulses"}, 32'({frame_err, crc_err, trans_valid}), 32'd0);
    endtask

    // Monitor: every output pulse consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge sb_clk);
            if (trans_valid || crc_err || frame_err) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse actual=%b required=none",
                             {frame_err, crc_err, trans_valid});
                end else begin
                    e = expq.pop_front();
                    chk("pulse", 32'({frame_err, crc_err, trans_valid}), 32'(e.pulse));
                    chk("type",  32'(trans_type), 32'(e.typ));
                    chk("addr",  32'(rx_addr), 32'(e.addr));
                    chk("len",   32'(rx_len),  32'(e.len));
                    chk("data",  32'(rx_data), 32'(e.data));
                    chk("lse",   32'(rx_lse),  32'(e.lse));
                end
            end
        end
    end

    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [7:0]  a, l, x;
        logic [23:0] d;
        logic [2:0]  typ;
        int          kind;

        rst = 1'b1; rx_valid = 1'b0; rx_en = 1'b1; rx_byte = 8'h00;
        m_typ = '0; m_addr = '0; m_len = '0; m_lse = '0; m_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_fields("reset");

        // Directed frames.
        fr = {8'hFE, 8'h80, 8'h7F}; expect_lt(); send_frame(1'b1); drain();
        fr = {8'hFE, 8'h80, 8'h7E}; push(3'b100); send_frame(1'b1); drain();
        mk_at(3'd2, 8'hA5, 8'h24, 24'h0, 16'h0, 8'hFE, 8'h40);
        expect_at(3'd2, 8'hA5, 8'h24, 24'h0); send_frame(1'b1); drain();
        mk_at(3'd2, 8'h5A, 8'h42, 24'h0, 16'h0100, 8'hFE, 8'h40);
        push(3'b010); send_frame(1'b1); drain();
        mk_at(3'd3, 8'h0C, 8'h03, 24'h332211, 16'h0, 8'hFE, 8'h40);
        expect_at(3'd3, 8'h0C, 8'h03, 24'h332211); send_frame(1'b1); drain();
        mk_at(3'd2, 8'h11, 8'h22, 24'h0, 16'h0, 8'hFE, 8'h40);
        fr.push_front(8'hFE);
        expect_at(3'd2, 8'h11, 8'h22, 24'h0); send_frame(1'b1); drain();
        fr = {8'hFE, 8'h12}; push(3'b100); send_frame(1'b1); drain();

        // Stall one cycle short of the limit: still a good frame.
        mk_at(3'd3, 8'h0D, 8'h03, 24'hC0FFEE, 16'h0, 8'hFE, 8'h40);
        expect_at(3'd3, 8'h0D, 8'h03, 24'hC0FFEE);
        foreach (fr[i]) send(fr[i], (i == 5) ? TMO - 2 : 0);
        drain();

        // Stall to the limit; the late FE opens a fresh LT frame.
        mk_at(3'd3, 8'h0C, 8'h03, 24'h332211, 16'h0, 8'hFE, 8'h40);
        push(3'b100);
        expect_lt();
        for (int i = 0; i < 6; i++) send(fr[i], (i == 5) ? TMO - 1 : 0);
        fr = {8'hFE, 8'h80, 8'h7F}; send_frame(1'b1); drain();

        // Link drop mid-response, and bytes ignored while down.
        mk_at(3'd3, 8'h0C, 8'h03, 24'h332211, 16'h0, 8'hFE, 8'h40);
        for (int i = 0; i < 5; i++) send(fr[i], 0);
        rx_en = 1'b0;
        send(8'hFE, 0); send(8'h80, 0); send(8'h7F, 0);
        rx_en = 1'b1;
        drain();
        mk_at(3'd2, 8'h33, 8'h44, 24'h0, 16'h0, 8'hFE, 8'h40);
        expect_at(3'd2, 8'h33, 8'h44, 24'h0); send_frame(1'b1); drain();

        // Reset mid-response.
        mk_at(3'd3, 8'h0C, 8'h03, 24'h332211, 16'h0, 8'hFE, 8'h40);
        for (int i = 0; i < 6; i++) send(fr[i], 0);
        rst = 1'b1;
        tick();
        m_typ = '0; m_addr = '0; m_len = '0; m_lse = '0; m_data = '0;
        chk_fields("midrst");
        rst = 1'b0;
        drain();
        mk_at(3'd3, 8'h01, 8'h03, 24'hABCDEF, 16'h0, 8'hFE, 8'h40);
        expect_at(3'd3, 8'h01, 8'h03, 24'hABCDEF); send_frame(1'b1); drain();

        // Randomized frames with junk between them.
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) begin
                do x = 8'($urandom); while (x == 8'hFE);
                send(x, $urandom_range(0, 2));
            end
            kind = $urandom_range(0, 8);
            a = 8'($urandom); l = 8'($urandom); d = 24'($urandom);
            typ = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'd2;
            case (kind)
                0: begin fr = {8'hFE, 8'h80, 8'h7F}; expect_lt(); end
                1: begin
                    do x = 8'($urandom); while (x == 8'h7F);
                    fr = {8'hFE, 8'h80, x}; push(3'b100);
                end
                2, 3: begin
                    mk_at(3'(kind), a, l, d, 16'h0, 8'hFE, 8'h40);
                    expect_at(3'(kind), a, l, d);
                end
                4: begin
                    mk_at(typ, a, l, d, 16'h1 << $urandom_range(0, 15), 8'hFE, 8'h40);
                    push(3'b010);
                end
                5: begin
                    do x = 8'($urandom);
                    while (x == 8'h05 || x == 8'h04 || x == 8'h80 || x == 8'hFE);
                    fr = {8'hFE, x}; push(3'b100);
                end
                6: begin
                    do x = 8'($urandom); while (x == 8'hFE);
                    mk_at(typ, a, l, d, 16'h0, x, 8'h40); push(3'b100);
                end
                7: begin
                    do x = 8'($urandom); while (x == 8'h40);
                    mk_at(typ, a, l, d, 16'h0, 8'hFE, x); push(3'b100);
                end
                default: begin
                    mk_at(typ, a, l, d, 16'h0, 8'hFE, 8'h40);
                    repeat ($urandom_range(1, 2)) fr.push_front(8'hFE);
                    expect_at(typ, a, l, d);
                end
            endcase
            send_frame(1'b0);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
